// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed, XOR-checksummed byte stream into
// instruction RAM, holding the CPU in reset until a good load releases it.
module prog_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_datain,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic              busy,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    // Word count must hold 256 (LEN byte of zero) even for small ADDR_W.
    localparam int CW = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA_HI, S_DATA_LO, S_CHK, S_START, S_RUN, S_ERROR
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_mem [2**ADDR_W];
    logic [ADDR_W-1:0]   r_waddr;
    logic [ADDR_W:0]     r_words;
    logic [CW-1:0]       r_count;
    logic [7:0]          r_hi;
    logic [7:0]          r_chk;
    logic                r_err;
    logic                w_xfer;
    logic                w_enter_len;
    logic                w_last;
    logic [DATA_W-1:0]   w_word;

    assign w_xfer      = rx_valid && rx_ready;
    assign w_enter_len = load_req &&
                         (r_state == S_IDLE || r_state == S_ERROR || r_state == S_RUN);
    assign w_last      = (CW'(r_words) + CW'(1)) == r_count;
    assign w_word      = DATA_W'({r_hi, rx_data});

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_ERROR, S_RUN: if (load_req) w_next = S_LEN;
            S_LEN:     if (w_xfer) w_next = S_DATA_HI;
            S_DATA_HI: if (w_xfer) w_next = S_DATA_LO;
            S_DATA_LO: if (w_xfer) w_next = w_last ? S_CHK : S_DATA_HI;
            S_CHK:     if (w_xfer) w_next = (rx_data == r_chk) ? S_START : S_ERROR;
            S_START:   w_next = S_RUN;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ready  = 1'b0;
        busy      = 1'b0;
        cpu_hold  = 1'b1;
        cpu_start = 1'b0;
        unique case (r_state)
            S_LEN, S_DATA_HI, S_DATA_LO, S_CHK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            S_START: begin
                cpu_hold  = 1'b0;
                cpu_start = 1'b1;
            end
            S_RUN:   cpu_hold = 1'b0;
            default: ;
        endcase
    end

    // Load bookkeeping is cleared on the edge that enters LEN, not while in it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_waddr <= '0;
            r_words <= '0;
            r_count <= '0;
            r_hi    <= '0;
            r_chk   <= '0;
            r_err   <= 1'b0;
        end else if (w_enter_len) begin
            r_waddr <= '0;
            r_words <= '0;
            r_chk   <= '0;
            r_err   <= 1'b0;
        end else if (w_xfer) begin
            unique case (r_state)
                S_LEN: begin
                    r_count <= (rx_data == 8'h00) ? CW'(256) : CW'(rx_data);
                    r_chk   <= rx_data;
                end
                S_DATA_HI: begin
                    r_hi  <= rx_data;
                    r_chk <= r_chk ^ rx_data;
                end
                S_DATA_LO: begin
                    r_chk   <= r_chk ^ rx_data;
                    r_waddr <= r_waddr + 1'b1;
                    r_words <= r_words + 1'b1;
                end
                S_CHK:   if (rx_data != r_chk) r_err <= 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (r_state == S_DATA_LO && w_xfer) begin
            r_mem[r_waddr] <= w_word;
        end
    end

    assign i_datain     = r_mem[i_addr];
    assign load_err     = r_err;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_prog_loader.sv
// Directed-plus-random bench for prog_loader against a byte-stream/RAM reference model.
module tb_prog_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        load_req;
    logic [7:0]  i_addr;
    logic [15:0] i_datain;
    logic        cpu_hold;
    logic        cpu_start;
    logic        busy;
    logic        load_err;
    logic [8:0]  words_loaded;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] model_mem  [256];
    logic [15:0] last_words [256];

    prog_loader #(.ADDR_W(8), .DATA_W(16)) dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .load_req(load_req), .i_addr(i_addr), .i_datain(i_datain),
        .cpu_hold(cpu_hold), .cpu_start(cpu_start), .busy(busy), .load_err(load_err),
        .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned cyc;
        bit got;
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clock); #1; end
        rx_data  = b;
        rx_valid = 1'b1;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 20) begin
            @(negedge clock);
            if (rx_ready) begin
                @(posedge clock); #1;
                got = 1'b1;
            end else begin
                cyc++;
            end
        end
        rx_valid = 1'b0;
        check("rx_accept", 32'(got), 32'd1);
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(posedge clock); #1;
        load_req = 1'b0;
    endtask

    task automatic check_ram(input string tag, input int unsigned n);
        for (int unsigned a = 0; a < n; a++) begin
            i_addr = 8'(a);
            #1;
            check(tag, 32'(i_datain), 32'(model_mem[a]));
        end
    endtask

    // Full load from request to START (good CHK) or ERROR (bad CHK); good loads end in RUN.
    task automatic run_load(input int unsigned nwords, input bit bad_chk, input int unsigned max_gap,
                            input bit req_in_hi, input bit reuse, input bit skip_req);
        logic [7:0] stream[$];
        logic [7:0] chk;
        logic [15:0] w;
        if (!skip_req) begin
            pulse_load();
            check("len_busy", 32'(busy), 32'd1);
            check("len_words_clr", 32'(words_loaded), 32'd0);
            check("len_err_clr", 32'(load_err), 32'd0);
        end
        stream.push_back((nwords == 256) ? 8'h00 : 8'(nwords));
        send_byte(stream[0], $urandom_range(max_gap, 0));
        for (int unsigned i = 0; i < nwords; i++) begin
            w = reuse ? last_words[i] : 16'($urandom);
            last_words[i] = w;
            if (req_in_hi && i == 1) begin
                pulse_load();
                check("req_hi_busy", 32'(busy), 32'd1);
                check("req_hi_words", 32'(words_loaded), 32'd1);
            end
            stream.push_back(w[15:8]);
            send_byte(w[15:8], $urandom_range(max_gap, 0));
            stream.push_back(w[7:0]);
            send_byte(w[7:0], $urandom_range(max_gap, 0));
            model_mem[i % 256] = w;
            i_addr = 8'(i % 256);
            #1;
            check("word_visible", 32'(i_datain), 32'(w));
            check("word_count", 32'(words_loaded), i + 1);
        end
        chk = 8'h00;
        foreach (stream[k]) chk ^= stream[k];
        send_byte(bad_chk ? (chk ^ 8'h01) : chk, $urandom_range(max_gap, 0));
        if (bad_chk) begin
            check("bad_err", 32'(load_err), 32'd1);
            check("bad_start", 32'(cpu_start), 32'd0);
        end else begin
            check("good_start", 32'(cpu_start), 32'd1);
            check("good_hold", 32'(cpu_hold), 32'd0);
            @(posedge clock); #1;
            check("start_pulse_end", 32'(cpu_start), 32'd0);
            check("run_hold", 32'(cpu_hold), 32'd0);
            check("good_err", 32'(load_err), 32'd0);
        end
    endtask

    initial begin
        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        load_req = 1'b0;
        i_addr   = 8'h00;
        #3;
        check("rst_ready", 32'(rx_ready), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_start", 32'(cpu_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        #10 reset = 1'b1;
        @(posedge clock); #1;

        // Directed two-word load; load_req during START must be ignored.
        pulse_load();
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        send_byte(8'h42, 0);
        model_mem[0] = 16'h1234;
        model_mem[1] = 16'hABCD;
        check("d_start", 32'(cpu_start), 32'd1);
        check("d_hold", 32'(cpu_hold), 32'd0);
        load_req = 1'b1;
        @(posedge clock); #1;
        load_req = 1'b0;
        check("d_pulse_end", 32'(cpu_start), 32'd0);
        check("d_start_req_ignored", 32'(busy), 32'd0);
        check("d_run_hold", 32'(cpu_hold), 32'd0);
        @(posedge clock); #1;
        check("d_still_run", 32'(cpu_hold), 32'd0);
        i_addr = 8'h00; #1;
        check("d_word0", 32'(i_datain), 32'h1234);
        i_addr = 8'h01; #1;
        check("d_word1", 32'(i_datain), 32'hABCD);
        check("d_words", 32'(words_loaded), 32'd2);
        check("d_err", 32'(load_err), 32'd0);

        // Bad checksum
        pulse_load();
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        send_byte(8'h43, 0);
        check("e_err", 32'(load_err), 32'd1);
        check("e_hold", 32'(cpu_hold), 32'd1);
        check("e_ready", 32'(rx_ready), 32'd0);
        rx_data  = 8'h99;
        rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            check("e_no_start", 32'(cpu_start), 32'd0);
            check("e_hold_stay", 32'(cpu_hold), 32'd1);
            check("e_ready_stay", 32'(rx_ready), 32'd0);
        end
        rx_valid = 1'b0;

        // 256-word load via LEN=0x00
        run_load(256, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("full_words", 32'(words_loaded), 32'd256);
        check_ram("full_ram", 256);

        // Gap-free load, then identical data with random gaps, then bytes offered in RUN
        run_load(6, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        run_load(6, 1'b0, 3, 1'b0, 1'b1, 1'b0);
        check_ram("gap_ram", 6);
        check("gap_words", 32'(words_loaded), 32'd6);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("run_ready", 32'(rx_ready), 32'd0);
            check("run_hold_stay", 32'(cpu_hold), 32'd0);
        end
        rx_valid = 1'b0;
        @(posedge clock); #1;
        check("run_words_stay", 32'(words_loaded), 32'd6);

        // Reset mid-load after three bytes
        pulse_load();
        send_byte(8'h04, 0);
        send_byte(8'h5A, 0);
        send_byte(8'hA5, 0);
        model_mem[0] = 16'h5AA5;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_hold", 32'(cpu_hold), 32'd1);
        check("mid_rst_ready", 32'(rx_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_words", 32'(words_loaded), 32'd0);
        #3 reset = 1'b1;
        @(posedge clock); #1;
        check("post_rst_idle", 32'(cpu_hold), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_ram", 32'(i_datain), 32'(model_mem[i_addr]));
        run_load(4, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        check_ram("after_rst_ram", 4);

        // load_req ignored in DATA_HI, then honoured in RUN
        run_load(3, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        check("ign_words", 32'(words_loaded), 32'd3);
        check_ram("ign_ram", 3);
        pulse_load();
        check("reload_hold", 32'(cpu_hold), 32'd1);
        check("reload_busy", 32'(busy), 32'd1);
        check("reload_words", 32'(words_loaded), 32'd0);
        run_load(5, 1'b0, 2, 1'b0, 1'b0, 1'b1);
        check("reload_cnt", 32'(words_loaded), 32'd5);
        check_ram("reload_ram", 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
